// File: rtl/c_ext_pkg.sv
// Shared compressed-extension definitions: halfword type, fetch FSM states
// and the compressed-opcode test used by both fetch and decode.
package c_ext_pkg;

    typedef logic [15:0] halfword_t;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [1:0] C_OPCODE_FULL = 2'b11;
    localparam int         HQ_DEPTH      = 4;

    function automatic logic is_compressed(input halfword_t hw);
        return hw[1:0] != C_OPCODE_FULL;
    endfunction

endpackage

// File: rtl/c_halfword_queue.sv
// Four-entry halfword FIFO. Entry 0 is the head; push and pop move one or
// two halfwords per cycle and may happen together. Flush empties it.
module c_halfword_queue
    import c_ext_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [1:0]           push_cnt,
    input  halfword_t [1:0]      push_data,
    input  logic [1:0]           pop_cnt,
    output halfword_t [1:0]      head,
    output logic [2:0]           occ
);

    halfword_t [HQ_DEPTH-1:0] hq_q, hq_d;
    logic [2:0]               occ_q, occ_d;
    logic [2:0]               base;
    logic [63:0]              shifted, ins_data, ins_mask, ins_lane;

    // Pop shifts the whole array down; the pushed halfwords land right
    // behind whatever survives the pop.
    always_comb begin
        base     = occ_q - {1'b0, pop_cnt};
        shifted  = hq_q >> {pop_cnt, 4'b0000};
        ins_lane = {32'h0, (push_cnt == 2'd2) ? 32'hFFFF_FFFF :
                           (push_cnt == 2'd1) ? 32'h0000_FFFF : 32'h0};
        ins_data = {32'h0, push_data} << {base, 4'b0000};
        ins_mask = ins_lane << {base, 4'b0000};
        hq_d     = (shifted & ~ins_mask) | (ins_data & ins_mask);
        occ_d    = base + {1'b0, push_cnt};
        if (flush) occ_d = 3'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hq_q  <= '0;
            occ_q <= 3'd0;
        end else begin
            hq_q  <= hq_d;
            occ_q <= occ_d;
        end
    end

    assign head = hq_q[1:0];
    assign occ  = occ_q;

endmodule

// File: rtl/c_fetch_align_ctrl.sv
// Fetch sequencer and halfword aligner feeding the decode path.
// Define C_EXT_EN to enable 16-bit instructions; otherwise everything is 32-bit.
module c_fetch_align_ctrl
    import c_ext_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_is_comp_o
);

    fetch_state_e    state_q, state_d;
    logic [31:0]     pc_q, fa_q;
    logic            skip_lo_q;
    halfword_t [1:0] head;
    logic [2:0]      occ, occ_after;
    logic            head_comp, hq_valid, fire;
    logic [1:0]      pop_cnt, push_cnt;
    halfword_t [1:0] push_data;
    logic            fetch_req, gnt_acc;
    logic [31:0]     redir_pc;
    logic            redir_skip;

    localparam logic [31:0] RESET_FA = {RESET_PC[31:2], 2'b00};

`ifdef C_EXT_EN
    localparam logic [31:0] RESET_PC_A = {RESET_PC[31:1], 1'b0};
    localparam logic        RESET_SKIP = RESET_PC[1];
    logic unused_redir;

    assign head_comp    = is_compressed(head[0]);
    assign redir_pc     = {redirect_pc_i[31:1], 1'b0};
    assign redir_skip   = redirect_pc_i[1];
    assign unused_redir = redirect_pc_i[0];
`else
    localparam logic [31:0] RESET_PC_A = RESET_FA;
    localparam logic        RESET_SKIP = 1'b0;
    logic [1:0] unused_redir;

    assign head_comp    = 1'b0;
    assign redir_pc     = {redirect_pc_i[31:2], 2'b00};
    assign redir_skip   = 1'b0;
    assign unused_redir = redirect_pc_i[1:0];
`endif

    c_halfword_queue u_hq (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_i),
        .push_cnt  (push_cnt),
        .push_data (push_data),
        .pop_cnt   (pop_cnt),
        .head      (head),
        .occ       (occ)
    );

    assign hq_valid      = head_comp ? (occ != 3'd0) : (occ >= 3'd2);
    assign instr_valid_o = hq_valid && !reset;
    assign fire          = instr_valid_o && instr_ready_i;
    assign pop_cnt       = !fire ? 2'd0 : (head_comp ? 2'd1 : 2'd2);
    assign occ_after     = occ - {1'b0, pop_cnt};

    assign instr_o         = !instr_valid_o ? 32'h0 :
                             head_comp      ? {16'h0, head[0]} : {head[1], head[0]};
    assign instr_is_comp_o = instr_valid_o && head_comp;
    assign instr_pc_o      = pc_q;

    // Only request when a full word is guaranteed to fit, so the queue
    // never overflows even with no dequeue before the response.
    assign fetch_req  = (state_q == S_FETCH) && !reset && (occ_after <= 3'd2);
    assign mem_req_o  = fetch_req;
    assign mem_addr_o = fa_q;
    assign gnt_acc    = fetch_req && mem_gnt_i;

    // First word after a redirect to an odd halfword only contributes [31:16].
    assign push_data = {mem_rdata_i[31:16],
                        skip_lo_q ? mem_rdata_i[31:16] : mem_rdata_i[15:0]};

    always_comb begin
        state_d  = state_q;
        push_cnt = 2'd0;
        if (reset) begin
            // A granted-but-unanswered fetch must still be soaked up.
            if ((state_q == S_WAIT || state_q == S_DISCARD) && !mem_rvalid_i)
                state_d = S_DISCARD;
            else
                state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (gnt_acc) state_d = redirect_i ? S_DISCARD : S_WAIT;
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        state_d = S_FETCH;
                        if (!redirect_i) push_cnt = skip_lo_q ? 2'd1 : 2'd2;
                    end else if (redirect_i) begin
                        state_d = S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (mem_rvalid_i) state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        if (reset) begin
            pc_q      <= RESET_PC_A;
            fa_q      <= RESET_FA;
            skip_lo_q <= RESET_SKIP;
        end else if (redirect_i) begin
            pc_q      <= redir_pc;
            fa_q      <= {redirect_pc_i[31:2], 2'b00};
            skip_lo_q <= redir_skip;
        end else begin
            if (fire)             pc_q      <= pc_q + (head_comp ? 32'd2 : 32'd4);
            if (gnt_acc)          fa_q      <= fa_q + 32'd4;
            if (push_cnt != 2'd0) skip_lo_q <= 1'b0;
        end
    end

endmodule
